// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Round-robin arbiter sharing one WIDTH-bit register among N_REQ writers.
// Revision : 1.0
// ============================================================================
module reg_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int IDXW  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [IDXW-1:0]        owner,
    output logic                   busy,
    output logic [7:0]             wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  r_winner;
    logic [IDXW-1:0]  r_ptr;
    logic [IDXW-1:0]  w_sel;
    logic [IDXW-1:0]  w_ptr_nxt;
    logic             w_any;
    logic             w_load;
    int               w_idx;
    logic [N_REQ-1:0] w_onehot;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [IDXW-1:0]  r_owner;
    logic [7:0]       r_wr_count;

    // Walk the search order backwards so the lowest offset from r_ptr wins.
    always_comb begin
        w_sel = r_ptr;
        w_any = 1'b0;
        w_idx = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (req[w_idx]) begin
                w_sel = IDXW'(w_idx);
                w_any = 1'b1;
            end
        end
    end

    assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << r_winner;
    assign w_ptr_nxt = (r_winner == IDXW'(N_REQ - 1)) ? '0 : r_winner + IDXW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        grant       = '0;
        ack         = '0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                grant = w_onehot;
                busy  = 1'b1;
                // A requester that drops its request here aborts the write.
                if (req[r_winner]) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ACK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACK: begin
                ack         = w_onehot;
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_winner   <= '0;
            r_ptr      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_owner    <= '0;
            r_wr_count <= 8'd0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_winner <= w_sel;
            end
            if (w_load) begin
                r_q        <= wdata[r_winner*WIDTH +: WIDTH];
                r_q_valid  <= 1'b1;
                r_owner    <= r_winner;
                r_ptr      <= w_ptr_nxt;
                r_wr_count <= r_wr_count + 8'd1;
            end
        end
    end

    assign q        = r_q;
    assign q_valid  = r_q_valid;
    assign owner    = r_owner;
    assign wr_count = r_wr_count;

endmodule
`default_nettype wire
